// File: rtl/ecc_mem_ctrl_if.sv
// Request/response bundle for ecc_mem_ctrl. The codeword width is derived
// from D_W the same way as inside the controller.
interface ecc_mem_ctrl_if #(
  parameter int D_W   = 32,
  parameter int A_W   = 2,
  parameter int CNT_W = 16
);
  function automatic int calc_p(input int dw);
    int p;
    p = 1;
    while ((2 ** p) < (dw + p + 1)) p = p + 1;
    return p;
  endfunction

  localparam int P    = calc_p(D_W);
  localparam int CW_W = D_W + P + 1;

  logic             en;
  logic             we;
  logic [A_W-1:0]   addr;
  logic [D_W-1:0]   wdata;
  logic [CW_W-1:0]  inj_mask;
  logic             ready;
  logic             rvalid;
  logic [D_W-1:0]   rdata;
  logic [1:0]       err;
  logic [CNT_W-1:0] sec_cnt;
  logic [CNT_W-1:0] ded_cnt;

  modport master (
    output en, we, addr, wdata, inj_mask,
    input  ready, rvalid, rdata, err, sec_cnt, ded_cnt
  );

  modport slave (
    input  en, we, addr, wdata, inj_mask,
    output ready, rvalid, rdata, err, sec_cnt, ded_cnt
  );
endinterface

// File: rtl/ecc_mem_ctrl.sv
// SECDED-protected single-port memory controller with programmable
// write/read latency and saturating error counters.
// Optional scrub write-back of corrected words: define SCRUB_WB_EN.
//
// state | meaning
// IDLE  | ready for a request
// WRITE | waiting W_LAT edges, then stores the codeword
// READ  | waiting R_LAT edges, then registers the decoded result
// SCRUB | (SCRUB_WB_EN) writing back a corrected codeword after W_LAT edges
module ecc_mem_ctrl #(
  parameter int D_W   = 32,
  parameter int A_W   = 2,
  parameter int W_LAT = 4,
  parameter int R_LAT = 5,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  ecc_mem_ctrl_if.slave bus
);
  function automatic int calc_p(input int dw);
    int p;
    p = 1;
    while ((2 ** p) < (dw + p + 1)) p = p + 1;
    return p;
  endfunction

  localparam int P     = calc_p(D_W);
  localparam int CW_W  = D_W + P + 1;
  localparam int CI_W  = $clog2(CW_W);
  localparam int DI_W  = $clog2(D_W);
  localparam int MAXL  = (W_LAT > R_LAT) ? W_LAT : R_LAT;
  localparam int LAT_W = $clog2(MAXL) + 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
`ifdef SCRUB_WB_EN
    SCRUB,
`endif
    READ
  } state_t;

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  lat_q;
  logic [A_W-1:0]    addr_q;
  logic [CW_W-1:0]   cw_q;
  logic              rvalid_q;
  logic [D_W-1:0]    rdata_q;
  logic [1:0]        err_q;
  logic [CNT_W-1:0]  sec_q, ded_q;
  logic [CW_W-1:0]   mem [2**A_W];

  logic [CW_W-1:0]   raw_c, fixed_c;
  logic [P-1:0]      syn_c;
  logic              par_c;
  logic [1:0]        err_c;
  logic [D_W-1:0]    data_c;
  logic              wr_fire;

  // Data bits fill non-power-of-two positions; parity bit 2^i covers positions with bit i set.
  function automatic logic [CW_W-1:0] encode(input logic [D_W-1:0] d);
    logic [CW_W-1:0] cw;
    int j;
    cw = '0;
    j  = 0;
    for (int k = 1; k < CW_W; k++) begin
      if ((k & (k - 1)) != 0) begin
        cw[CI_W'(k)] = d[DI_W'(j)];
        j = j + 1;
      end
    end
    for (int i = 0; i < P; i++) begin
      for (int k = 1; k < CW_W; k++) begin
        if ((((k >> i) & 1) == 1) && (k != (1 << i)))
          cw[CI_W'(1 << i)] = cw[CI_W'(1 << i)] ^ cw[CI_W'(k)];
      end
    end
    cw[0] = ^cw[CW_W-1:1];
    return cw;
  endfunction

  function automatic logic [D_W-1:0] extract(input logic [CW_W-1:0] cw);
    logic [D_W-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int k = 1; k < CW_W; k++) begin
      if ((k & (k - 1)) != 0) begin
        d[DI_W'(j)] = cw[CI_W'(k)];
        j = j + 1;
      end
    end
    return d;
  endfunction

  // Decode the addressed word: syndrome, overall parity, correction and class.
  always_comb begin
    raw_c   = mem[addr_q];
    syn_c   = '0;
    par_c   = ^raw_c;
    for (int k = 1; k < CW_W; k++)
      if (raw_c[CI_W'(k)]) syn_c = syn_c ^ P'(k);
    fixed_c = raw_c;
    for (int k = 0; k < CW_W; k++)
      if (par_c && (syn_c == P'(k))) fixed_c[CI_W'(k)] = ~raw_c[CI_W'(k)];
    if (par_c)               err_c = 2'd1;
    else if (syn_c != '0)    err_c = 2'd2;
    else                     err_c = 2'd0;
    data_c  = (err_c == 2'd2) ? extract(raw_c) : extract(fixed_c);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: leave WRITE/READ/SCRUB when the latency counter hits zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.en) state_d = bus.we ? READ : WRITE;
      WRITE: if (lat_q == '0) state_d = IDLE;
      READ: begin
        if (lat_q == '0) begin
          state_d = IDLE;
`ifdef SCRUB_WB_EN
          if (err_c == 2'd1) state_d = SCRUB;
`endif
        end
      end
`ifdef SCRUB_WB_EN
      SCRUB: if (lat_q == '0) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Request capture, latency countdown, read result and error counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_q    <= '0;
      addr_q   <= '0;
      cw_q     <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 2'd0;
      sec_q    <= '0;
      ded_q    <= '0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.en) begin
            addr_q <= bus.addr;
            cw_q   <= encode(bus.wdata) ^ bus.inj_mask;
            lat_q  <= bus.we ? LAT_W'(R_LAT - 1) : LAT_W'(W_LAT - 1);
          end
        end
        READ: begin
          if (lat_q != '0) begin
            lat_q <= lat_q - 1'b1;
          end else begin
            rvalid_q <= 1'b1;
            rdata_q  <= data_c;
            err_q    <= err_c;
            if (err_c == 2'd1 && sec_q != '1) sec_q <= sec_q + 1'b1;
            if (err_c == 2'd2 && ded_q != '1) ded_q <= ded_q + 1'b1;
`ifdef SCRUB_WB_EN
            if (err_c == 2'd1) begin
              cw_q  <= encode(data_c);
              lat_q <= LAT_W'(W_LAT - 1);
            end
`endif
          end
        end
        default: if (lat_q != '0) lat_q <= lat_q - 1'b1;
      endcase
    end
  end

`ifdef SCRUB_WB_EN
  assign wr_fire = ((state_q == WRITE) || (state_q == SCRUB)) && (lat_q == '0);
`else
  assign wr_fire = (state_q == WRITE) && (lat_q == '0);
`endif

  // Array store; contents survive reset, but a reset edge cancels the store.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire) mem[addr_q] <= cw_q;
  end

  assign bus.ready   = (state_q == IDLE);
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.err     = err_q;
  assign bus.sec_cnt = sec_q;
  assign bus.ded_cnt = ded_q;
endmodule

// File: tb/tb_ecc_mem_ctrl.sv
// Directed bench for ecc_mem_ctrl (CNT_W=2 so counter saturation is reachable).
module tb_ecc_mem_ctrl;
  localparam int D_W   = 32;
  localparam int A_W   = 2;
  localparam int W_LAT = 4;
  localparam int R_LAT = 5;
  localparam int CNT_W = 2;
`ifdef SCRUB_WB_EN
  localparam int SL = W_LAT;
`else
  localparam int SL = 0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   exp_sec;
  int   exp_ded;

  ecc_mem_ctrl_if #(.D_W(D_W), .A_W(A_W), .CNT_W(CNT_W)) bus ();

  ecc_mem_ctrl #(.D_W(D_W), .A_W(A_W), .W_LAT(W_LAT), .R_LAT(R_LAT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic inc_sec();
    if (exp_sec < 3) exp_sec++;
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_sec"}, 64'(bus.sec_cnt), 64'(exp_sec));
    check({tag, "_ded"}, 64'(bus.ded_cnt), 64'(exp_ded));
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d, input logic [38:0] m);
    int low;
    @(negedge clk);
    check("wr_ready", 64'(bus.ready), 64'd1);
    bus.en = 1'b1; bus.we = 1'b0; bus.addr = a; bus.wdata = d; bus.inj_mask = m;
    @(posedge clk);
    @(negedge clk);
    bus.en = 1'b0;
    low = 0;
    while (!bus.ready && low < 20) begin
      low++;
      @(negedge clk);
    end
    check("wr_busy", 64'(low), 64'(W_LAT));
  endtask

  task automatic do_read(input logic [1:0] a, input logic [31:0] exp_d, input logic [1:0] exp_e,
                         input int exp_low);
    int k;
    int low;
    @(negedge clk);
    check("rd_ready", 64'(bus.ready), 64'd1);
    bus.en = 1'b1; bus.we = 1'b1; bus.addr = a; bus.inj_mask = '0;
    @(posedge clk);
    @(negedge clk);
    bus.en = 1'b0;
    k = 0;
    while (!bus.rvalid && k < 20) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    check("rd_latency", 64'(k), 64'(R_LAT));
    check("rd_data", 64'(bus.rdata), 64'(exp_d));
    check("rd_err", 64'(bus.err), 64'(exp_e));
    low = bus.ready ? 0 : 1;
    @(negedge clk);
    check("rv_pulse", 64'(bus.rvalid), 64'd0);
    check("rd_hold", 64'(bus.rdata), 64'(exp_d));
    while (!bus.ready && low < 20) begin
      low++;
      @(negedge clk);
    end
    check("rd_busy_after", 64'(low), 64'(exp_low));
  endtask

  logic [31:0] vals [3];
  int idx, nrv, cyc;
  logic rdy;

  initial begin
    checks = 0; failures = 0; exp_sec = 0; exp_ded = 0;
    vals[0] = 32'h1111_1111; vals[1] = 32'h2222_3333; vals[2] = 32'hCAFE_F00D;
    rst = 1'b1;
    bus.en = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.inj_mask = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_rvalid", 64'(bus.rvalid), 64'd0);
    check("rst_rdata", 64'(bus.rdata), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check_cnts("rst");
    rst = 1'b0;

    // Clean write/read.
    do_write(2'd1, 32'hDEADBEEF, 39'h0);
    do_read(2'd1, 32'hDEADBEEF, 2'd0, 0);
    check_cnts("clean");

    // Single error on data bit 0 (position 3).
    do_write(2'd2, 32'hDEADBEEF, 39'h8);
    do_read(2'd2, 32'hDEADBEEF, 2'd1, SL);
    inc_sec();
    check_cnts("sec1");
`ifdef SCRUB_WB_EN
    do_read(2'd2, 32'hDEADBEEF, 2'd0, 0);
`else
    do_read(2'd2, 32'hDEADBEEF, 2'd1, 0);
    inc_sec();
`endif
    check_cnts("reread");

    // Double error: positions 3 (data bit 0) and 4 (parity) -> raw data bit 0 flipped.
    do_write(2'd3, 32'hDEADBEEF, 39'h18);
    do_read(2'd3, 32'hDEADBEEE, 2'd2, 0);
    exp_ded++;
    check_cnts("ded");

    // Overall parity bit only.
    do_write(2'd0, 32'h12345678, 39'h1);
    do_read(2'd0, 32'h12345678, 2'd1, SL);
    inc_sec();
    check_cnts("p0");

    // Reset two cycles into a write; the store must be cancelled.
    @(negedge clk);
    bus.en = 1'b1; bus.we = 1'b0; bus.addr = 2'd1; bus.wdata = 32'hA5A5A5A5; bus.inj_mask = '0;
    @(posedge clk);
    @(negedge clk);
    bus.en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_sec = 0; exp_ded = 0;
    check("mid_rst_ready", 64'(bus.ready), 64'd1);
    check("mid_rst_rvalid", 64'(bus.rvalid), 64'd0);
    check("mid_rst_rdata", 64'(bus.rdata), 64'd0);
    check("mid_rst_err", 64'(bus.err), 64'd0);
    check_cnts("mid_rst");
    do_read(2'd1, 32'hDEADBEEF, 2'd0, 0);

    // Counter saturation at 3 with CNT_W=2.
    for (int n = 0; n < 5; n++) begin
      do_write(2'd2, 32'h0F0F0F0F, 39'h8);
      do_read(2'd2, 32'h0F0F0F0F, 2'd1, SL);
      inc_sec();
      check_cnts("sat");
    end

    // en held high with alternating write/read to one address.
    idx = 0; nrv = 0; cyc = 0;
    while ((idx < 6 || nrv < 3) && cyc < 300) begin
      @(negedge clk);
      if (bus.rvalid) begin
        if (nrv < 3) begin
          check("burst_rdata", 64'(bus.rdata), 64'(vals[nrv]));
          check("burst_err", 64'(bus.err), 64'd0);
        end
        nrv++;
      end
      rdy = bus.ready;
      if (idx < 6) begin
        bus.en = 1'b1; bus.we = idx[0]; bus.addr = 2'd3; bus.inj_mask = '0;
        bus.wdata = vals[idx / 2];
      end else begin
        bus.en = 1'b0;
      end
      @(posedge clk);
      if (idx < 6 && rdy) idx++;
      cyc++;
    end
    bus.en = 1'b0;
    check("burst_accepts", 64'(idx), 64'd6);
    check("burst_reads", 64'(nrv), 64'd3);
    repeat (3) @(negedge clk);
    check("burst_no_extra_rvalid", 64'(bus.rvalid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
